of_ex_latch: RTL and testbench
==============================

// Module: of_ex_latch
// PURPOSE
//  Pipeline register between operand fetch (operand_select / operand muxes) and execute.
//  Carries pc, inst, op1, op2, immx and control bits with a valid/ready handshake.
//  Detects load-use hazards and inserts LD_BUBBLES bubbles toward execute.
//  Also takes a flush from the branch unit.
// PARAMETERS
//  XLEN        32  datapath width of pc/inst/op1/op2/immx
//  CTRL_W      12  width of opaque control bundle (isRet,isSt,isImmediate,isCall,alu op...)
//  REG_AW       4  register index width (16 registers, ra = r15)
//  LD_BUBBLES   1  bubbles inserted on load-use; legal 1..3
// PORTS
//  clk          in   1       rising-edge clock
//  rst_n        in   1       asynchronous active-low reset
//  flush        in   1       kill EX slot and refuse input this cycle
//  in_valid     in   1       OF presents an instruction
//  in_ready     out  1       latch accepts this cycle
//  in_pc        in   XLEN    instruction pc
//  in_inst      in   XLEN    raw instruction
//  in_op1       in   XLEN    operand 1
//  in_op2       in   XLEN    operand 2
//  in_immx      in   XLEN    extended immediate
//  in_ctrl      in   CTRL_W  control bundle
//  in_rs1       in   REG_AW  source 1 index (15 for ret)
//  in_rs2       in   REG_AW  source 2 index (rd for st)
//  in_use_rs1   in   1       rs1 actually read
//  in_use_rs2   in   1       rs2 actually read
//  in_rd        in   REG_AW  destination index (15 for call)
//  in_is_ld     in   1       instruction is a load
//  in_is_wb     in   1       instruction writes the register file
//  out_valid    out  1       EX slot holds a real instruction
//  out_ready    in   1       EX consumes the slot this cycle
//  out_pc, out_inst, out_op1, out_op2, out_immx  out XLEN  registered copies
//  out_ctrl     out  CTRL_W  registered control
//  out_rd       out  REG_AW  registered destination
//  out_is_ld    out  1       registered load flag
//  out_is_wb    out  1       registered writeback flag
// BEHAVIOUR
//  - Reset (async, rst_n=0): out_valid=0, all out_* payload=0, pend_cnt=0, pend_rd=0, perf counters=0.
//  - Latency: 1 cycle. An accepted instruction appears on out_* after the next rising edge.
//  - match(r) = (in_use_rs1 && in_rs1==r) || (in_use_rs2 && in_rs2==r).
//  - hazard = in_valid && ( (out_valid && out_is_ld && out_is_wb && match(out_rd))
//            || (pend_cnt!=0 && match(pend_rd)) ).
//  - advance = !out_valid || out_ready.
//  - in_ready = advance && !hazard && !flush (combinational).
//  - Edge priority: flush > advance > hold.
//    - flush: out_valid<=0; payload don't-care; the input is dropped.
//    - advance and in_valid and !hazard: load all in_* into out_*; out_valid<=1.
//    - advance otherwise: out_valid<=0 (bubble); payload holds.
//    - !advance: all out_* hold stable (required under backpressure).
//  - Pending-load tracker (LD_BUBBLES>1 only):
//    - when out_valid && out_ready && out_is_ld && out_is_wb (and no flush):
//      pend_rd<=out_rd, pend_cnt<=LD_BUBBLES-1.
//    - else if pend_cnt!=0 && out_ready: pend_cnt<=pend_cnt-1.
//    - flush does not clear pend_*, because an older load still completes.
//  - Net effect: a dependent instruction directly after a load sees exactly LD_BUBBLES bubbles,
//    given out_ready held 1.
//  - Upstream re-samples operands while in_ready=0, so the stalled instruction reads updated registers.
//  - A load with in_is_wb=0 never causes a hazard.
//  - in_rd is never compared against itself.
//  - in_valid=0 with advance: the slot becomes a bubble; no hazard is counted.
// CONFIGURATION
//  - OF_EX_PERF_EN defined: adds ports perf_bubbles (out, 32) and perf_flushes (out, 16).
//    - perf_bubbles increments on every edge where advance && hazard && !flush.
//    - perf_flushes increments on every edge where flush=1.
//    - Both wrap on overflow and reset to 0.
//  - OF_EX_PERF_EN undefined: ports and counters are absent; other behaviour is identical.
// TESTING
//  1. out_valid=1, out_pc=0x40, then rst_n=0 mid-cycle -> out_valid=0 and out_pc=0 before the next edge.
//  2. Three ALU ops pc=0x0,0x4,0x8, out_ready=1 -> out_pc 0x0,0x4,0x8 on consecutive cycles, in_ready=1 throughout.
//  3. ld r3, then add r4,r3,r5 (use_rs1, rs1=3):
//     - LD_BUBBLES=1 -> one out_valid=0 cycle, in_ready=0 for one cycle.
//     - LD_BUBBLES=3 -> three bubbles.
//  4. ld r3 followed by add r4,r5,r6 -> no bubble. ld r3 with in_is_wb=0 followed by a reader of r3 -> no bubble.
//  5. out_ready=0 for 3 cycles while in_valid=1 -> out_* stable, in_ready=0.
//     Then out_ready=1 -> the next instruction loads on the following edge.
//  6. flush=1 with in_valid=1, pc=0x20:
//     - out_valid=0 next cycle; 0x20 is never issued.
//     - A pending load's pend_cnt is unchanged.
//     - perf_flushes=1 when OF_EX_PERF_EN is defined.

Source files
------------

// File: rtl/of_ex_latch.sv
// Operand-fetch to execute pipeline register with valid/ready handshake, load-use
// bubble insertion and branch flush. Define OF_EX_PERF_EN to add bubble/flush counters.
module of_ex_latch #(
    parameter int XLEN       = 32,
    parameter int CTRL_W     = 12,
    parameter int REG_AW     = 4,
    parameter int LD_BUBBLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [XLEN-1:0]   in_inst,
    input  logic [XLEN-1:0]   in_op1,
    input  logic [XLEN-1:0]   in_op2,
    input  logic [XLEN-1:0]   in_immx,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [REG_AW-1:0] in_rs1,
    input  logic [REG_AW-1:0] in_rs2,
    input  logic              in_use_rs1,
    input  logic              in_use_rs2,
    input  logic [REG_AW-1:0] in_rd,
    input  logic              in_is_ld,
    input  logic              in_is_wb,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc,
    output logic [XLEN-1:0]   out_inst,
    output logic [XLEN-1:0]   out_op1,
    output logic [XLEN-1:0]   out_op2,
    output logic [XLEN-1:0]   out_immx,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [REG_AW-1:0] out_rd,
    output logic              out_is_ld,
    output logic              out_is_wb
`ifdef OF_EX_PERF_EN
    ,
    output logic [31:0]       perf_bubbles,
    output logic [15:0]       perf_flushes
`endif
);

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   inst;
        logic [XLEN-1:0]   op1;
        logic [XLEN-1:0]   op2;
        logic [XLEN-1:0]   immx;
        logic [CTRL_W-1:0] ctrl;
        logic [REG_AW-1:0] rd;
        logic              is_ld;
        logic              is_wb;
    } payload_t;

    payload_t          r_pl;
    logic              r_valid;
    logic [1:0]        r_pend_cnt;
    logic [REG_AW-1:0] r_pend_rd;

    payload_t          w_in_pl;
    logic              w_match_out;
    logic              w_match_pend;
    logic              w_hazard;
    logic              w_advance;
    logic              w_accept;
    logic              w_ld_done;

    assign w_in_pl = '{pc: in_pc, inst: in_inst, op1: in_op1, op2: in_op2, immx: in_immx,
                       ctrl: in_ctrl, rd: in_rd, is_ld: in_is_ld, is_wb: in_is_wb};

    assign w_match_out  = (in_use_rs1 && (in_rs1 == r_pl.rd)) || (in_use_rs2 && (in_rs2 == r_pl.rd));
    assign w_match_pend = (in_use_rs1 && (in_rs1 == r_pend_rd)) || (in_use_rs2 && (in_rs2 == r_pend_rd));

    // A load in EX stalls its reader; for LD_BUBBLES>1 the tracker keeps stalling after it leaves.
    assign w_hazard  = in_valid && ((r_valid && r_pl.is_ld && r_pl.is_wb && w_match_out)
                                    || ((r_pend_cnt != 2'd0) && w_match_pend));
    assign w_advance = !r_valid || out_ready;
    assign in_ready  = w_advance && !w_hazard && !flush;
    assign w_accept  = in_valid && in_ready;
    assign w_ld_done = r_valid && out_ready && r_pl.is_ld && r_pl.is_wb && !flush;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_pl    <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_advance) begin
            r_valid <= w_accept;
            if (w_accept) begin
                r_pl <= w_in_pl;
            end
        end
    end

    // Flush leaves the tracker alone: the older load has already left EX and still completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_cnt <= 2'd0;
            r_pend_rd  <= '0;
        end else if (w_ld_done) begin
            r_pend_rd  <= r_pl.rd;
            r_pend_cnt <= 2'(LD_BUBBLES - 1);
        end else if ((r_pend_cnt != 2'd0) && out_ready) begin
            r_pend_cnt <= r_pend_cnt - 2'd1;
        end
    end

    assign out_valid = r_valid;
    assign out_pc    = r_pl.pc;
    assign out_inst  = r_pl.inst;
    assign out_op1   = r_pl.op1;
    assign out_op2   = r_pl.op2;
    assign out_immx  = r_pl.immx;
    assign out_ctrl  = r_pl.ctrl;
    assign out_rd    = r_pl.rd;
    assign out_is_ld = r_pl.is_ld;
    assign out_is_wb = r_pl.is_wb;

`ifdef OF_EX_PERF_EN
    logic [31:0] r_perf_bubbles;
    logic [15:0] r_perf_flushes;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_bubbles <= 32'd0;
            r_perf_flushes <= 16'd0;
        end else begin
            if (flush) begin
                r_perf_flushes <= r_perf_flushes + 16'd1;
            end
            if (w_advance && w_hazard && !flush) begin
                r_perf_bubbles <= r_perf_bubbles + 32'd1;
            end
        end
    end

    assign perf_bubbles = r_perf_bubbles;
    assign perf_flushes = r_perf_flushes;
`endif

endmodule

// File: tb/tb_of_ex_latch.sv
// Bench for of_ex_latch: two instances (LD_BUBBLES=1 and 3) share stimulus and are
// compared every cycle against a cycle-level model, plus hand-computed directed checks.
module tb_of_ex_latch;

    localparam int LB_A = 1;
    localparam int LB_B = 3;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] immx;
        logic [11:0] ctrl;
        logic [3:0]  rd;
        logic        is_ld;
        logic        is_wb;
    } pl_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_pc = '0, in_inst = '0, in_op1 = '0, in_op2 = '0, in_immx = '0;
    logic [11:0] in_ctrl = '0;
    logic [3:0]  in_rs1 = '0, in_rs2 = '0, in_rd = '0;
    logic        in_use_rs1 = 1'b0, in_use_rs2 = 1'b0, in_is_ld = 1'b0, in_is_wb = 1'b0;
    logic        out_ready = 1'b1;

    logic        a_in_ready, a_out_valid, a_out_is_ld, a_out_is_wb;
    logic [31:0] a_out_pc, a_out_inst, a_out_op1, a_out_op2, a_out_immx;
    logic [11:0] a_out_ctrl;
    logic [3:0]  a_out_rd;
    logic        b_in_ready, b_out_valid, b_out_is_ld, b_out_is_wb;
    logic [31:0] b_out_pc, b_out_inst, b_out_op1, b_out_op2, b_out_immx;
    logic [11:0] b_out_ctrl;
    logic [3:0]  b_out_rd;
`ifdef OF_EX_PERF_EN
    logic [31:0] a_perf_bubbles, b_perf_bubbles;
    logic [15:0] a_perf_flushes, b_perf_flushes;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    of_ex_latch #(.XLEN(32), .CTRL_W(12), .REG_AW(4), .LD_BUBBLES(LB_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_pc(in_pc), .in_inst(in_inst), .in_op1(in_op1), .in_op2(in_op2), .in_immx(in_immx),
        .in_ctrl(in_ctrl), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_use_rs1(in_use_rs1),
        .in_use_rs2(in_use_rs2), .in_rd(in_rd), .in_is_ld(in_is_ld), .in_is_wb(in_is_wb),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_pc(a_out_pc), .out_inst(a_out_inst),
        .out_op1(a_out_op1), .out_op2(a_out_op2), .out_immx(a_out_immx), .out_ctrl(a_out_ctrl),
        .out_rd(a_out_rd), .out_is_ld(a_out_is_ld), .out_is_wb(a_out_is_wb)
`ifdef OF_EX_PERF_EN
        , .perf_bubbles(a_perf_bubbles), .perf_flushes(a_perf_flushes)
`endif
    );

    of_ex_latch #(.XLEN(32), .CTRL_W(12), .REG_AW(4), .LD_BUBBLES(LB_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_pc(in_pc), .in_inst(in_inst), .in_op1(in_op1), .in_op2(in_op2), .in_immx(in_immx),
        .in_ctrl(in_ctrl), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_use_rs1(in_use_rs1),
        .in_use_rs2(in_use_rs2), .in_rd(in_rd), .in_is_ld(in_is_ld), .in_is_wb(in_is_wb),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_pc(b_out_pc), .out_inst(b_out_inst),
        .out_op1(b_out_op1), .out_op2(b_out_op2), .out_immx(b_out_immx), .out_ctrl(b_out_ctrl),
        .out_rd(b_out_rd), .out_is_ld(b_out_is_ld), .out_is_wb(b_out_is_wb)
`ifdef OF_EX_PERF_EN
        , .perf_bubbles(b_perf_bubbles), .perf_flushes(b_perf_flushes)
`endif
    );

    pl_t a_got, b_got;
    assign a_got = {a_out_pc, a_out_inst, a_out_op1, a_out_op2, a_out_immx, a_out_ctrl, a_out_rd, a_out_is_ld, a_out_is_wb};
    assign b_got = {b_out_pc, b_out_inst, b_out_op1, b_out_op2, b_out_immx, b_out_ctrl, b_out_rd, b_out_is_ld, b_out_is_wb};

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Per instance: what sits in EX, and how many out_ready cycles have passed since the
    // last load-with-writeback left EX (that load blocks readers for LD_BUBBLES-1 of them).
    logic        m_valid [2];
    pl_t         m_pl    [2];
    logic        m_known [2];
    logic [3:0]  m_ld_rd [2];
    int          m_since [2];
    logic [31:0] m_bub   [2];
    logic [15:0] m_fl    [2];

    function automatic int lb(input int k);
        return (k == 0) ? LB_A : LB_B;
    endfunction

    function automatic logic reads(input logic [3:0] r);
        return (in_use_rs1 && in_rs1 == r) || (in_use_rs2 && in_rs2 == r);
    endfunction

    function automatic logic m_hazard(input int k);
        if (!in_valid) return 1'b0;
        if (m_valid[k] && m_pl[k].is_ld && m_pl[k].is_wb && reads(m_pl[k].rd)) return 1'b1;
        return (m_since[k] < lb(k) - 1) && reads(m_ld_rd[k]);
    endfunction

    function automatic logic m_in_ready(input int k);
        return (!m_valid[k] || out_ready) && !m_hazard(k) && !flush;
    endfunction

    function automatic pl_t cur_in();
        return {in_pc, in_inst, in_op1, in_op2, in_immx, in_ctrl, in_rd, in_is_ld, in_is_wb};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_valid[k] <= 1'b0;
                m_pl[k]    <= '0;
                m_known[k] <= 1'b1;
                m_ld_rd[k] <= '0;
                m_since[k] <= 1000;
                m_bub[k]   <= '0;
                m_fl[k]    <= '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (m_valid[k] && out_ready && m_pl[k].is_ld && m_pl[k].is_wb && !flush) begin
                    m_ld_rd[k] <= m_pl[k].rd;
                    m_since[k] <= 0;
                end else if (out_ready && m_since[k] < 1000) begin
                    m_since[k] <= m_since[k] + 1;
                end
                if (flush) begin
                    m_valid[k] <= 1'b0;
                    m_known[k] <= 1'b0;
                    m_fl[k]    <= m_fl[k] + 16'd1;
                end else if (!m_valid[k] || out_ready) begin
                    if (m_hazard(k)) m_bub[k] <= m_bub[k] + 32'd1;
                    if (in_valid && !m_hazard(k)) begin
                        m_valid[k] <= 1'b1;
                        m_pl[k]    <= cur_in();
                        m_known[k] <= 1'b1;
                    end else begin
                        m_valid[k] <= 1'b0;
                    end
                end
            end
        end
    end

    // Compare process: outputs and combinational in_ready, mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            check("a_in_ready", 256'(a_in_ready), 256'(m_in_ready(0)));
            check("b_in_ready", 256'(b_in_ready), 256'(m_in_ready(1)));
            check("a_out_valid", 256'(a_out_valid), 256'(m_valid[0]));
            check("b_out_valid", 256'(b_out_valid), 256'(m_valid[1]));
            if (m_known[0]) check("a_payload", 256'(a_got), 256'(m_pl[0]));
            if (m_known[1]) check("b_payload", 256'(b_got), 256'(m_pl[1]));
`ifdef OF_EX_PERF_EN
            check("a_perf_bubbles", 256'(a_perf_bubbles), 256'(m_bub[0]));
            check("b_perf_bubbles", 256'(b_perf_bubbles), 256'(m_bub[1]));
            check("a_perf_flushes", 256'(a_perf_flushes), 256'(m_fl[0]));
            check("b_perf_flushes", 256'(b_perf_flushes), 256'(m_fl[1]));
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [3:0] rs1, input logic u1,
                         input logic [3:0] rs2, input logic u2, input logic [3:0] rd,
                         input logic ld, input logic wb);
        in_valid = v;          in_pc = pc;               in_inst = pc ^ 32'h1357_9bdf;
        in_op1 = pc + 32'h100; in_op2 = pc + 32'h200;    in_immx = ~pc;
        in_ctrl = pc[11:0] ^ 12'ha5c;
        in_rs1 = rs1; in_use_rs1 = u1; in_rs2 = rs2; in_use_rs2 = u2;
        in_rd = rd;   in_is_ld = ld;   in_is_wb = wb;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset_a_valid", 256'(a_out_valid), 256'(0));
        check("reset_a_pc", 256'(a_out_pc), 256'(0));
        check("reset_b_valid", 256'(b_out_valid), 256'(0));
        check("reset_b_inst", 256'(b_out_inst), 256'(0));
        rst_n = 1'b1;

        // Back-to-back ALU ops issue on consecutive cycles.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'(i * 4), 4'd0, 1'b0, 4'd0, 1'b0, 4'd1, 1'b0, 1'b1);
            #1;
            check("alu_a_in_ready", 256'(a_in_ready), 256'(1));
            check("alu_b_in_ready", 256'(b_in_ready), 256'(1));
            cyc();
            check("alu_a_pc", 256'(a_out_pc), 256'(i * 4));
            check("alu_b_valid", 256'(b_out_valid), 256'(1));
        end
        idle();
        cyc();

        // ld r3 then a reader of r3: 1 bubble on A, 3 on B.
        drive(1'b1, 32'h10, 4'd0, 1'b0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b1);
        cyc();
        drive(1'b1, 32'h14, 4'd3, 1'b1, 4'd5, 1'b0, 4'd4, 1'b0, 1'b1);
        #1;
        check("lu_a_stall", 256'(a_in_ready), 256'(0));
        check("lu_b_stall", 256'(b_in_ready), 256'(0));
        cyc();
        check("lu_a_bubble", 256'(a_out_valid), 256'(0));
        check("lu_b_bubble1", 256'(b_out_valid), 256'(0));
        check("lu_a_ready", 256'(a_in_ready), 256'(1));
        check("lu_b_stall1", 256'(b_in_ready), 256'(0));
        cyc();
        check("lu_a_issue", 256'(a_out_valid), 256'(1));
        check("lu_a_pc", 256'(a_out_pc), 256'h14);
        check("lu_b_bubble2", 256'(b_out_valid), 256'(0));
        check("lu_b_stall2", 256'(b_in_ready), 256'(0));
        cyc();
        check("lu_b_bubble3", 256'(b_out_valid), 256'(0));
        check("lu_b_ready", 256'(b_in_ready), 256'(1));
        cyc();
        check("lu_b_issue", 256'(b_out_valid), 256'(1));
        check("lu_b_pc", 256'(b_out_pc), 256'h14);
`ifdef OF_EX_PERF_EN
        check("lu_a_perf", 256'(a_perf_bubbles), 256'(1));
        check("lu_b_perf", 256'(b_perf_bubbles), 256'(3));
`endif
        idle();
        cyc();

        // Independent reader after a load, and a reader after a non-writing load: no bubble.
        drive(1'b1, 32'h30, 4'd0, 1'b0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b1);
        cyc();
        drive(1'b1, 32'h34, 4'd5, 1'b1, 4'd6, 1'b1, 4'd4, 1'b0, 1'b1);
        #1;
        check("indep_a_ready", 256'(a_in_ready), 256'(1));
        check("indep_b_ready", 256'(b_in_ready), 256'(1));
        cyc();
        check("indep_b_pc", 256'(b_out_pc), 256'h34);
        idle();
        repeat (3) cyc();
        drive(1'b1, 32'h40, 4'd0, 1'b0, 4'd0, 1'b0, 4'd7, 1'b1, 1'b0);
        cyc();
        drive(1'b1, 32'h44, 4'd7, 1'b1, 4'd0, 1'b0, 4'd8, 1'b0, 1'b1);
        #1;
        check("nowb_b_ready", 256'(b_in_ready), 256'(1));
        cyc();
        check("nowb_a_pc", 256'(a_out_pc), 256'h44);
        idle();
        cyc();

        // Backpressure holds the slot and stalls upstream.
        drive(1'b1, 32'h50, 4'd0, 1'b0, 4'd0, 1'b0, 4'd1, 1'b0, 1'b1);
        cyc();
        out_ready = 1'b0;
        drive(1'b1, 32'h54, 4'd0, 1'b0, 4'd0, 1'b0, 4'd2, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_a_stall", 256'(a_in_ready), 256'(0));
            cyc();
            check("bp_a_pc", 256'(a_out_pc), 256'h50);
            check("bp_b_valid", 256'(b_out_valid), 256'(1));
        end
        out_ready = 1'b1;
        #1;
        check("bp_a_release", 256'(a_in_ready), 256'(1));
        cyc();
        check("bp_a_next", 256'(a_out_pc), 256'h54);
        idle();
        cyc();

        // Flush drops the input and keeps a pending load's stall (out_ready low so no countdown).
        drive(1'b1, 32'h60, 4'd0, 1'b0, 4'd0, 1'b0, 4'd9, 1'b1, 1'b1);
        cyc();
        idle();
        cyc();
        flush = 1'b1;
        out_ready = 1'b0;
        drive(1'b1, 32'h20, 4'd0, 1'b0, 4'd0, 1'b0, 4'd2, 1'b0, 1'b1);
        #1;
        check("fl_a_refuse", 256'(a_in_ready), 256'(0));
        cyc();
        flush = 1'b0;
        out_ready = 1'b1;
        check("fl_a_valid", 256'(a_out_valid), 256'(0));
        check("fl_b_valid", 256'(b_out_valid), 256'(0));
`ifdef OF_EX_PERF_EN
        check("fl_a_perf", 256'(a_perf_flushes), 256'(1));
`endif
        drive(1'b1, 32'h64, 4'd9, 1'b1, 4'd0, 1'b0, 4'd10, 1'b0, 1'b1);
        #1;
        check("fl_a_ready", 256'(a_in_ready), 256'(1));
        check("fl_b_pend2", 256'(b_in_ready), 256'(0));
        cyc();
        check("fl_b_pend1", 256'(b_in_ready), 256'(0));
        cyc();
        check("fl_b_clear", 256'(b_in_ready), 256'(1));
        idle();
        cyc();

        // Asynchronous reset mid-cycle clears the slot before the next edge.
        drive(1'b1, 32'h40, 4'd0, 1'b0, 4'd0, 1'b0, 4'd1, 1'b0, 1'b1);
        cyc();
        check("ar_a_pc_before", 256'(a_out_pc), 256'h40);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_a_valid", 256'(a_out_valid), 256'(0));
        check("ar_a_pc", 256'(a_out_pc), 256'(0));
        check("ar_b_pc", 256'(b_out_pc), 256'(0));
        idle();
        cyc();
        rst_n = 1'b1;

        // Randomized traffic with a small register range so hazards are frequent.
        for (int i = 0; i < 3000; i++) begin
            cyc();
            drive($urandom_range(0, 3) != 0, $urandom, 4'($urandom_range(0, 3)), 1'($urandom),
                  4'($urandom_range(0, 3)), 1'($urandom), 4'($urandom_range(0, 3)),
                  $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0);
            in_op1    = $urandom;
            flush     = ($urandom_range(0, 15) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
        end
        cyc();
        flush = 1'b0;
        idle();
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
